e_reduce_acc: RTL
=================

E_REDUCE_ACC -- requirements
Module: e_reduce_acc

Interface
REQ-001 Parameter B, default 5: input word width in bits, B >= 1.
REQ-002 Parameter N, default 3: words per frame, N >= 1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 clr  input  1  synchronous frame abort, active-high.
REQ-006 mode  input  2  reduction operator: 0=AND, 1=OR, 2=XOR, 3=XNOR.
REQ-007 in_valid  input  1  in_word is valid this cycle.
REQ-008 in_ready  output  1  block can accept a word this cycle.
REQ-009 in_word  input  B  data word.
REQ-010 out_valid  output  1  frame result is available.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 col_out  output  B  column-wise reduction of all words in the frame.
REQ-013 red_out  output  1  full reduction of col_out under the frame mode.
REQ-014 busy  output  1  high whenever state != IDLE.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ACC, HOLD.
REQ-016 A word SHALL be accepted only on a rising edge where in_valid=1, in_ready=1 and clr=0.
REQ-017 in_ready SHALL be 1 in IDLE and ACC, and 0 in HOLD.
REQ-018 IDLE accept behaviour:
- latch mode into the frame-mode register;
- acc <= in_word; cnt <= 1;
- go to HOLD if N==1, otherwise go to ACC.
REQ-019 ACC accept behaviour:
- acc <= acc op in_word, bitwise, where op is AND, OR or XOR (XOR for mode 3);
- cnt <= cnt+1;
- go to HOLD when the Nth word is accepted.
REQ-020 In ACC with no accept, state, acc and cnt SHALL hold their values; idle cycles between words are allowed.
REQ-021 The mode input SHALL be ignored outside the IDLE accept cycle; the latched frame mode governs the whole frame.
REQ-022 out_valid SHALL be 1 exactly while in HOLD, starting the cycle after the Nth word is accepted (latency 1 cycle).
REQ-023 In HOLD, col_out=acc, and red_out SHALL be:
- &acc for AND, |acc for OR, ^acc for XOR;
- ~^acc for XNOR.
REQ-024 col_out and red_out SHALL be 0 whenever out_valid=0.
REQ-025 In HOLD with out_ready=1, the FSM SHALL go to IDLE on that edge, with cnt <= 0 and acc <= 0.
REQ-026 In HOLD with out_ready=0, all outputs SHALL stay stable, and in_valid SHALL be ignored.
REQ-027 clr=1 in any state SHALL force IDLE, cnt=0 and acc=0 on that edge.
REQ-028 clr SHALL take priority over in_valid and out_ready in the same cycle.
REQ-029 cnt width SHALL be $clog2(N+1), and cnt SHALL never exceed N.
REQ-030 A result discarded by clr while in HOLD SHALL not be re-presented.

Reset
REQ-031 While rst_n=0, asynchronously and independent of clk, the block SHALL be in this state:
- state=IDLE, acc=0, cnt=0, frame mode=0;
- out_valid=0, col_out=0, red_out=0, busy=0, in_ready=1.
REQ-032 Deasserting rst_n SHALL take effect on the next rising edge; deassertion mid-frame SHALL start a fresh frame.
REQ-033 Reset asserted during ACC or HOLD SHALL discard the partial frame or pending result.

Verification (B=5, N=3)
REQ-034 Reset: pulse rst_n low between clock edges -> all outputs are at their REQ-031 values immediately, without waiting for an edge.
REQ-035 AND frame:
- stimulus: mode=0, words 11111, 11011, 11111 on consecutive cycles, out_ready=1;
- response: next cycle out_valid=1, col_out=11011, red_out=0; following cycle out_valid=0 and in IDLE.
REQ-036 OR frame with gaps:
- stimulus: mode=1, words 00000, 00010, 00000 with in_valid low for 2 cycles between words;
- response: col_out=00010, red_out=1.
REQ-037 XOR vs XNOR:
- stimulus: words 01010, 10011, 00010;
- mode=2 -> col_out=11011, red_out=0;
- repeat with mode=3 -> col_out=11011, red_out=1.
REQ-038 Backpressure:
- stimulus: AND frame, out_ready=0 for 4 cycles with in_valid=1 held;
- response: out_valid, col_out and red_out stay constant, in_ready=0, no word is consumed;
- then out_ready=1 -> IDLE.
REQ-039 Abort and mode change:
- stimulus: XOR frame, clr=1 after 2 words; then OR frame 00001, 00000, 00000 with mode toggled to 0 after the first word;
- response: result col_out=00001, red_out=1 (OR retained).

Source files
------------

// File: rtl/e_reduce_acc.sv
// e_reduce_acc
//    Collects a frame of N words of B bits and reduces them column-wise
//    with a bitwise operator chosen at the start of the frame. The column
//    result is then reduced to a single bit. The result is held until the
//    consumer accepts it.
//
// Ports
//    clk        single clock, rising edge
//    rst_n      asynchronous active-low reset
//    clr        synchronous frame abort (wins over in_valid / out_ready)
//    mode       operator: 0=AND, 1=OR, 2=XOR, 3=XNOR (sampled on the first word)
//    in_valid   in_word is valid
//    in_ready   block accepts a word this cycle (low only while holding a result)
//    in_word    data word, B bits
//    out_valid  frame result available
//    out_ready  consumer takes the result
//    col_out    column-wise reduction of the frame (0 when out_valid=0)
//    red_out    full reduction of col_out under the frame mode (0 when out_valid=0)
//    busy       high whenever a frame is in progress or a result is held
module e_reduce_acc #(
   parameter int B = 5,
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clr,
   input  logic [1:0]   mode,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [B-1:0] in_word,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [B-1:0] col_out,
   output logic         red_out,
   output logic         busy
);

   localparam int CW = $clog2(N + 1);
   localparam logic [CW-1:0] N_CNT = CW'(N);
   localparam logic [CW-1:0] ONE_CNT = CW'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t         state_r, nxt_state_s;
   logic [B-1:0]   acc_r, nxt_acc_s;
   logic [CW-1:0]  cnt_r, nxt_cnt_s;
   logic [1:0]     mode_r, nxt_mode_s;

   logic           in_ready_r, out_valid_r, red_out_r, busy_r;
   logic [B-1:0]   col_out_r;

   // Column operator; XNOR frames accumulate with XOR, the inversion only
   // applies to the final single-bit reduction.
   function automatic logic [B-1:0] combine(input logic [B-1:0] a,
                                            input logic [B-1:0] b,
                                            input logic [1:0]   m);
      logic [B-1:0] r;
      case (m)
         2'd0:    r = a & b;
         2'd1:    r = a | b;
         default: r = a ^ b;
      endcase
      return r;
   endfunction

   // Single-bit reduction of the accumulated column word.
   function automatic logic reduce_bits(input logic [B-1:0] v,
                                        input logic [1:0]   m);
      logic r;
      case (m)
         2'd0:    r = &v;
         2'd1:    r = |v;
         2'd2:    r = ^v;
         default: r = ~^v;
      endcase
      return r;
   endfunction

   // Next-state and next-datapath computation.
   always_comb begin
      nxt_state_s = state_r;
      nxt_acc_s   = acc_r;
      nxt_cnt_s   = cnt_r;
      nxt_mode_s  = mode_r;
      if (clr) begin
         nxt_state_s = IDLE;
         nxt_acc_s   = '0;
         nxt_cnt_s   = '0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  nxt_mode_s  = mode;
                  nxt_acc_s   = in_word;
                  nxt_cnt_s   = ONE_CNT;
                  nxt_state_s = (N_CNT == ONE_CNT) ? HOLD : ACC;
               end else begin
                  nxt_state_s = IDLE;
               end
            end
            ACC: begin
               if (in_valid) begin
                  nxt_acc_s   = combine(acc_r, in_word, mode_r);
                  nxt_cnt_s   = cnt_r + ONE_CNT;
                  nxt_state_s = ((cnt_r + ONE_CNT) == N_CNT) ? HOLD : ACC;
               end else begin
                  nxt_state_s = ACC;
               end
            end
            HOLD: begin
               // in_valid is ignored here; only the consumer can release.
               if (out_ready) begin
                  nxt_state_s = IDLE;
                  nxt_acc_s   = '0;
                  nxt_cnt_s   = '0;
               end else begin
                  nxt_state_s = HOLD;
               end
            end
            default: begin
               nxt_state_s = IDLE;
               nxt_acc_s   = '0;
               nxt_cnt_s   = '0;
            end
         endcase
      end
   end

   // State, datapath and outputs; outputs are registered from the next state
   // so they line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         acc_r       <= '0;
         cnt_r       <= '0;
         mode_r      <= 2'd0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
         col_out_r   <= '0;
         red_out_r   <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         state_r     <= nxt_state_s;
         acc_r       <= nxt_acc_s;
         cnt_r       <= nxt_cnt_s;
         mode_r      <= nxt_mode_s;
         in_ready_r  <= (nxt_state_s != HOLD);
         out_valid_r <= (nxt_state_s == HOLD);
         col_out_r   <= (nxt_state_s == HOLD) ? nxt_acc_s : '0;
         red_out_r   <= (nxt_state_s == HOLD) ? reduce_bits(nxt_acc_s, nxt_mode_s) : 1'b0;
         busy_r      <= (nxt_state_s != IDLE);
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign col_out   = col_out_r;
   assign red_out   = red_out_r;
   assign busy      = busy_r;

endmodule
